// File: rtl/conv_layer_sched.sv
// Sequencer for the convolution engine: layer-0 3x3 zero-padded conv walk,
// then 2x2 stride-2 max-pool over the layer-0 map. Address and strobes only.
module conv_layer_sched #(
    parameter int IMG_LOG2 = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ready,
    output logic                    busy,
    output logic [2*IMG_LOG2-1:0]   iaddr,
    output logic                    pad,
    output logic                    mac_clr,
    output logic                    mac_en,
    output logic [3:0]              tap_idx,
    output logic                    pool_clr,
    output logic                    pool_en,
    output logic                    cwr,
    output logic [2*IMG_LOG2-1:0]   caddr_wr,
    output logic                    crd,
    output logic [2*IMG_LOG2-1:0]   caddr_rd,
    output logic [2:0]              csel
);

    localparam int L  = IMG_LOG2;
    localparam int AW = 2 * IMG_LOG2;

    localparam logic [2:0] CS_NONE = 3'b000;
    localparam logic [2:0] CS_L0   = 3'b001;
    localparam logic [2:0] CS_L1   = 3'b011;

    localparam logic signed [L+1:0] MONE = '1;
    localparam logic signed [L+1:0] ZERO = '0;
    localparam logic signed [L+1:0] ONE  = {{(L+1){1'b0}}, 1'b1};
    localparam logic signed [L+1:0] MAXC = {2'b00, {L{1'b1}}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CONV_TAP = 3'd1,
        CONV_WR  = 3'd2,
        POOL_RD  = 3'd3,
        POOL_WR  = 3'd4,
        DONE     = 3'd5
    } state_t;

    typedef struct packed {
        logic          busy;
        logic [AW-1:0] iaddr;
        logic          pad;
        logic          mac_clr;
        logic          mac_en;
        logic [3:0]    tap_idx;
        logic          pool_clr;
        logic          pool_en;
        logic          cwr;
        logic [AW-1:0] caddr_wr;
        logic          crd;
        logic [AW-1:0] caddr_rd;
        logic [2:0]    csel;
    } ctl_t;

    state_t         st, st_n;
    logic [3:0]     k, k_n;
    logic [L-1:0]   row, col, row_n, col_n;
    logic [1:0]     j, j_n;
    logic [L-2:0]   r, c, r_n, c_n;
    ctl_t           ctl_p0;

    // Output decode of a (state, counters) tuple; applied to the next state so
    // every port is a flop that lines up with the state it describes.
    function automatic ctl_t decode(input state_t s, input logic [3:0] kk,
                                    input logic [L-1:0] rw, input logic [L-1:0] cl,
                                    input logic [1:0] jj, input logic [L-2:0] pr,
                                    input logic [L-2:0] pc);
        ctl_t o;
        logic signed [L+1:0] dy, dx, tr, tc;
        o  = '0;
        dy = ZERO;
        dx = ZERO;
        tr = ZERO;
        tc = ZERO;
        o.busy = (s != IDLE);
        case (s)
            CONV_TAP: begin
                dy = (kk < 4'd3) ? MONE : ((kk < 4'd6) ? ZERO : ONE);
                case (kk)
                    4'd0, 4'd3, 4'd6: dx = MONE;
                    4'd1, 4'd4, 4'd7: dx = ZERO;
                    default:          dx = ONE;
                endcase
                // Two guard bits keep -1 and 2^L distinct from in-range values.
                tr = $signed({2'b00, rw}) + dy;
                tc = $signed({2'b00, cl}) + dx;
                o.pad = (tr < ZERO) || (tr > MAXC) || (tc < ZERO) || (tc > MAXC);
                if (!o.pad) o.iaddr = {tr[L-1:0], tc[L-1:0]};
                o.tap_idx = kk;
                o.mac_en  = 1'b1;
                o.mac_clr = (kk == 4'd0);
            end
            CONV_WR: begin
                o.cwr      = 1'b1;
                o.csel     = CS_L0;
                o.caddr_wr = {rw, cl};
            end
            POOL_RD: begin
                o.crd      = 1'b1;
                o.csel     = CS_L0;
                o.caddr_rd = {pr, jj[1], pc, jj[0]};
                o.pool_clr = (jj == 2'd0);
                o.pool_en  = (jj != 2'd0);
            end
            POOL_WR: begin
                o.cwr      = 1'b1;
                o.csel     = CS_L1;
                o.caddr_wr = {2'b00, pr, pc};
            end
            default: o.csel = CS_NONE;
        endcase
        return o;
    endfunction

    always_comb begin
        st_n  = st;
        k_n   = k;
        row_n = row;
        col_n = col;
        j_n   = j;
        r_n   = r;
        c_n   = c;
        case (st)
            IDLE: begin
                if (ready) begin
                    st_n  = CONV_TAP;
                    k_n   = 4'd0;
                    row_n = '0;
                    col_n = '0;
                end
            end
            CONV_TAP: begin
                if (k == 4'd8) st_n = CONV_WR;
                else           k_n  = k + 4'd1;
            end
            CONV_WR: begin
                k_n   = 4'd0;
                col_n = col + L'(1);
                if (col == '1) row_n = row + L'(1);
                if (row == '1 && col == '1) begin
                    st_n = POOL_RD;
                    j_n  = 2'd0;
                    r_n  = '0;
                    c_n  = '0;
                end else begin
                    st_n = CONV_TAP;
                end
            end
            POOL_RD: begin
                if (j == 2'd3) st_n = POOL_WR;
                else           j_n  = j + 2'd1;
            end
            POOL_WR: begin
                j_n = 2'd0;
                c_n = c + (L-1)'(1);
                if (c == '1) r_n = r + (L-1)'(1);
                st_n = (r == '1 && c == '1) ? DONE : POOL_RD;
            end
            DONE:    st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st     <= IDLE;
            k      <= '0;
            row    <= '0;
            col    <= '0;
            j      <= '0;
            r      <= '0;
            c      <= '0;
            ctl_p0 <= '0;
        end else begin
            st     <= st_n;
            k      <= k_n;
            row    <= row_n;
            col    <= col_n;
            j      <= j_n;
            r      <= r_n;
            c      <= c_n;
            ctl_p0 <= decode(st_n, k_n, row_n, col_n, j_n, r_n, c_n);
        end
    end

    assign busy     = ctl_p0.busy;
    assign iaddr    = ctl_p0.iaddr;
    assign pad      = ctl_p0.pad;
    assign mac_clr  = ctl_p0.mac_clr;
    assign mac_en   = ctl_p0.mac_en;
    assign tap_idx  = ctl_p0.tap_idx;
    assign pool_clr = ctl_p0.pool_clr;
    assign pool_en  = ctl_p0.pool_en;
    assign cwr      = ctl_p0.cwr;
    assign caddr_wr = ctl_p0.caddr_wr;
    assign crd      = ctl_p0.crd;
    assign caddr_rd = ctl_p0.caddr_rd;
    assign csel     = ctl_p0.csel;

endmodule
